// File: rtl/lut_scan_ctrl.sv
// Walks a 4-bit code through a downstream LUT, holds each code SETTLE_CYC cycles,
// samples the decode result and compares the captured truth map against EXP_MAP.
module lut_scan_ctrl #(
  parameter int unsigned SETTLE_CYC = 2,
  parameter logic [15:0] EXP_MAP    = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        s_i,
  output logic [3:0]  b_o,
  output logic        busy,
  output logic        done,
  output logic [15:0] map_o,
  output logic [4:0]  ones_cnt,
  output logic        pass_o
);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_t      state_q, state_d;
  logic [3:0]  code_q, code_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  b_q, b_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] map_q, map_d;
  logic [4:0]  ones_q, ones_d;
  logic        pass_q, pass_d;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    map_d   = map_q;
    ones_d  = ones_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          map_d   = '0;
          ones_d  = '0;
          pass_d  = 1'b0;
          code_d  = '0;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) state_d = SAMPLE;
      end
      SAMPLE: begin
        map_d[code_q] = s_i;
        ones_d        = ones_q + {4'b0, s_i};
        if (code_q == 4'hF) begin
          // Compare here so pass_o is already valid in the done cycle.
          pass_d  = (map_d == EXP_MAP);
          state_d = DONE;
        end else begin
          code_d  = code_q + 4'd1;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered from next-state so they line up with the state register.
    busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
    done_d = (state_d == DONE);
    b_d    = busy_d ? code_d : 4'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      cnt_q   <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      map_q   <= '0;
      ones_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      map_q   <= map_d;
      ones_q  <= ones_d;
      pass_q  <= pass_d;
    end
  end

  assign b_o      = b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign map_o    = map_q;
  assign ones_cnt = ones_q;
  assign pass_o   = pass_q;
endmodule

// File: tb/tb_lut_scan_ctrl.sv
// Directed bench for lut_scan_ctrl: three instances (plain, real-LUT, fast settle)
// with a scoreboard of expected scan results popped on each done pulse.
module tb_lut_scan_ctrl;
  localparam logic [15:0] LUT_MAP = 16'h2996;  // codes 1,2,4,7,8,11,13 decode to 1

  typedef struct {
    logic [15:0] m;
    logic [4:0]  o;
    logic        p;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_a = 0, start_b = 0, start_c = 0;
  logic        s_a = 0, inv_b = 0;
  logic        s_b;
  logic [3:0]  b_a, b_b, b_c;
  logic        busy_a, busy_b, busy_c, done_a, done_b, done_c, pass_a, pass_b, pass_c;
  logic [15:0] map_a, map_b, map_c;
  logic [4:0]  ones_a, ones_b, ones_c;

  function automatic logic lut(input logic [3:0] b);
    logic [15:0] t;
    t = LUT_MAP;
    return t[b];
  endfunction

  assign s_b = lut(b_b) ^ (inv_b && b_b == 4'd3);

  lut_scan_ctrl #(.SETTLE_CYC(2), .EXP_MAP(16'h0000)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .s_i(s_a), .b_o(b_a), .busy(busy_a),
    .done(done_a), .map_o(map_a), .ones_cnt(ones_a), .pass_o(pass_a));
  lut_scan_ctrl #(.SETTLE_CYC(2), .EXP_MAP(LUT_MAP)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .s_i(s_b), .b_o(b_b), .busy(busy_b),
    .done(done_b), .map_o(map_b), .ones_cnt(ones_b), .pass_o(pass_b));
  lut_scan_ctrl #(.SETTLE_CYC(1), .EXP_MAP(16'h0000)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .s_i(1'b0), .b_o(b_c), .busy(busy_c),
    .done(done_c), .map_o(map_c), .ones_cnt(ones_c), .pass_o(pass_c));

  int          sel = 0;
  logic [3:0]  b_m;
  logic        busy_m, done_m, pass_m;
  logic [15:0] map_m;
  logic [4:0]  ones_m;
  always_comb begin
    b_m = b_a; busy_m = busy_a; done_m = done_a; map_m = map_a; ones_m = ones_a; pass_m = pass_a;
    if (sel == 1) begin
      b_m = b_b; busy_m = busy_b; done_m = done_b; map_m = map_b; ones_m = ones_b; pass_m = pass_b;
    end else if (sel == 2) begin
      b_m = b_c; busy_m = busy_c; done_m = done_c; map_m = map_c; ones_m = ones_c; pass_m = pass_c;
    end
  end

  int   errors = 0;
  int   checks = 0;
  exp_t sbq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model of a full scan: map bit n is whatever the stimulus presents for code n.
  task automatic push_exp(input int which, input logic sval, input logic inv);
    exp_t e;
    e.m = '0;
    e.o = '0;
    for (int n = 0; n < 16; n++) begin
      logic bit_v;
      bit_v = (which == 1) ? (lut(4'(n)) ^ (inv && n == 3)) : sval;
      e.m[n] = bit_v;
      e.o = e.o + 5'(bit_v);
    end
    e.p = (e.m == ((which == 1) ? LUT_MAP : 16'h0000));
    sbq.push_back(e);
  endtask

  // Pulse start for one edge; returns at the negedge of the first busy cycle.
  task automatic kick(input int which);
    @(negedge clk);
    if (which == 0) start_a = 1; else if (which == 1) start_b = 1; else start_c = 1;
    @(negedge clk);
    if (which == 0) start_a = 0; else if (which == 1) start_b = 0; else start_c = 0;
  endtask

  // Follows one scan from its first busy cycle to done, checking timing, b_o and results.
  task automatic observe(input string tag, input int s, input bit mid, output int lat);
    int   bc, bad_b;
    bit   got;
    exp_t e;
    bc = 0; bad_b = 0; got = 0; lat = 0;
    while (lat < 400 && !got) begin
      if (done_m) got = 1;
      else begin
        if (busy_m) begin
          if (b_m != 4'(bc / (s + 1))) bad_b++;
          bc++;
        end
        lat++;
        if (sel == 0) start_a = mid && (bc == 5 * (s + 1) + 1);
        @(negedge clk);
      end
    end
    start_a = 0;
    chk({tag, ".done_seen"}, 32'(got), 1);
    chk({tag, ".busy_len"}, bc, 16 * (s + 1));
    chk({tag, ".done_lat"}, lat, 16 * (s + 1));
    chk({tag, ".b_seq_bad"}, bad_b, 0);
    if (sbq.size() == 0) chk({tag, ".sb_empty"}, 1, 0);
    else begin
      e = sbq.pop_front();
      chk({tag, ".map"}, 32'(map_m), 32'(e.m));
      chk({tag, ".ones"}, 32'(ones_m), 32'(e.o));
      chk({tag, ".pass"}, 32'(pass_m), 32'(e.p));
    end
    @(negedge clk);
    chk({tag, ".done_1cyc"}, 32'(done_m), 0);
    chk({tag, ".idle_busy"}, 32'(busy_m), 0);
    chk({tag, ".idle_b"}, 32'(b_m), 0);
    chk({tag, ".map_hold"}, 32'(map_m), 32'(e.m));
  endtask

  initial begin
    int lat, n, extra;
    #1;
    chk("rst.b", 32'(b_a), 0);
    chk("rst.busy", 32'(busy_a), 0);
    chk("rst.done", 32'(done_a), 0);
    chk("rst.map", 32'(map_a), 0);
    chk("rst.ones", 32'(ones_a), 0);
    chk("rst.pass", 32'(pass_a), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    // s_i tied 0, expected map all zeros.
    sel = 0; s_a = 0;
    push_exp(0, 0, 0); kick(0); observe("zero", 2, 0, lat);

    // s_i tied 1: count must reach 16 without wrapping.
    s_a = 1;
    push_exp(0, 1, 0); kick(0); observe("ones", 2, 0, lat);
    chk("ones.cnt16", 32'(ones_a), 16);

    // Real LUT, then with one decode output inverted.
    sel = 1;
    push_exp(1, 0, 0); kick(1); observe("lut", 2, 0, lat);
    inv_b = 1;
    push_exp(1, 0, 1); kick(1); observe("lut_inv", 2, 0, lat);
    inv_b = 0;

    // Second start at code 5 must neither restart nor queue.
    sel = 0; s_a = 0;
    push_exp(0, 0, 0); kick(0); observe("midstart", 2, 1, lat);
    extra = 0;
    repeat (60) begin @(negedge clk); if (done_a || busy_a) extra++; end
    chk("midstart.no_queue", extra, 0);

    // Reset mid-scan at code 9 clears partial data and suppresses done.
    s_a = 1;
    push_exp(0, 1, 0); kick(0);
    n = 0;
    while (b_a != 4'd9 && n < 100) begin @(negedge clk); n++; end
    chk("abort.reach9", 32'(b_a), 9);
    chk("abort.partial", 32'(ones_a != 0), 1);
    rst_n = 0;
    #1;
    chk("abort.b", 32'(b_a), 0);
    chk("abort.busy", 32'(busy_a), 0);
    chk("abort.map", 32'(map_a), 0);
    chk("abort.ones", 32'(ones_a), 0);
    chk("abort.pass", 32'(pass_a), 0);
    @(negedge clk);
    rst_n = 1;
    void'(sbq.pop_front());
    extra = 0;
    repeat (60) begin @(negedge clk); if (done_a || busy_a) extra++; end
    chk("abort.no_done", extra, 0);
    push_exp(0, 1, 0); kick(0); observe("after_rst", 2, 0, lat);

    // SETTLE_CYC=1 with start held: back-to-back scans, done pulses 34 apart.
    sel = 2;
    push_exp(2, 0, 0); push_exp(2, 0, 0);
    @(negedge clk); start_c = 1;
    @(negedge clk);
    observe("held1", 1, 0, lat);
    @(negedge clk);
    chk("held.restart_busy", 32'(busy_c), 1);
    start_c = 0;
    observe("held2", 1, 0, lat);
    chk("held.done_gap", 32'(lat + 2), 34);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
